mux_n_reg: RTL
==============

// Module: mux_n_reg
// PURPOSE
//  Parametrised N-channel, W-bit multiplexer with a registered valid/ready output stage.
//  Generalises the 8-bit 2:1 select used in the datapath: arbitrary width and channel count.
//  One selected channel per transfer; the result is held in an output register until consumed.
//  Sits between datapath producers (ALU, memory, immediate) and the register-file/bus write port.
// PARAMETERS
//  W   8  data width per channel, >=1
//  N   4  number of input channels, >=2
//  SW  localparam = $clog2(N); width of sel/out_ch (not overridable)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_data    in   N*W    channel i occupies bits [i*W +: W]
//  in_valid   in   N      per-channel data valid
//  in_ready   out  N      per-channel accept; one-hot or zero
//  sel        in   SW     channel select (fixed mode)
//  rr_mode    in   1      only with MUX_RR_EN: 1 = round-robin select, 0 = use sel
//  out_data   out  W      registered selected data
//  out_valid  out  1      out_data/out_ch hold a pending result
//  out_ready  in   1      downstream accept
//  out_ch     out  SW     index of the channel that produced out_data
// BEHAVIOUR
//  - Clock clk, reset rst: one clock; reset is synchronous and active-high.
//  - Reset values: out_valid=0, out_data=0, out_ch=0, rr pointer=N-1 (channel 0 served first).
//  - slot_free = !out_valid || out_ready (accept while draining: full throughput, 1 result/cycle).
//  - chosen channel c: fixed mode -> c=sel; in_ready[c]=slot_free, all other in_ready bits 0.
//  - sel >= N (non-power-of-2 N): no channel chosen, in_ready=0, no capture.
//  - Capture when in_valid[c] && in_ready[c]: next cycle out_data=in_data[c], out_ch=c, out_valid=1.
//  - Latency: input accepted at edge k appears on out_data after edge k (1 cycle).
//  - out_valid && !out_ready: out_data/out_ch/out_valid held stable; in_ready=0; sel changes ignored.
//  - out_valid && out_ready && no capture: out_valid->0, out_data/out_ch keep last value.
//  - in_valid on unselected channels is ignored (no side effect).
//  - in_ready is combinational from sel, rr state, out_valid and out_ready; never from in_valid in
//    fixed mode.
//  - rst asserted mid-transfer: pending output discarded, out_valid=0 next cycle, in_ready=0 that cycle.
//  - No X propagation: out_data updates only on capture or reset.
// CONFIGURATION
//  MUX_RR_EN defined: rr_mode port present. With rr_mode=1, c = first i with in_valid[i] searching
//   ptr+1, ptr+2, ... wrapping modulo N; none valid -> in_ready=0. in_ready depends on in_valid.
//   On capture ptr<=c; ptr unchanged otherwise and in fixed mode. Wrap: ptr=N-1 -> search starts at 0.
//  MUX_RR_EN undefined: no rr_mode port, no pointer register; fixed select only.
// TESTING
//  1 W=8,N=4: rst 2 cycles -> out_valid=0,out_data=0,in_ready=0000 when sel=0 & out_ready=0 & out_valid=0
//    -> in_ready=0001.
//  2 sel=2,in_valid=0100,in_data[2]=8'hA5,out_ready=1 -> next cycle out_data=A5,out_ch=2,out_valid=1.
//  3 out_ready=0 for 3 cycles, sel toggled 1->3 -> out_data=A5,out_ch=2 held, in_ready=0000 throughout.
//  4 back-to-back sel=1, data 11,22,33 over 3 cycles with out_ready=1 -> outputs 11,22,33 on consecutive
//    cycles, no bubbles.
//  5 N=3, sel=3, in_valid=111 -> in_ready=000, out_valid stays 0; rst mid-hold -> out_valid=0 next cycle.
//  6 MUX_RR_EN, rr_mode=1, in_valid=1011 held, out_ready=1 -> out_ch sequence 0,1,3,0,1,3.

Source files
------------

// File: rtl/mux_n_reg.sv
// mux_n_reg: N-channel, W-bit multiplexer with a registered valid/ready output stage.
// Define MUX_RR_EN to add the rr_mode port and the round-robin select pointer.
module mux_n_reg #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [$clog2(N)-1:0] sel,
`ifdef MUX_RR_EN
    input  logic                 rr_mode,
`endif
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_ch
);
    localparam int SW = $clog2(N);

    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] ch_q, ch_d;
    logic          valid_q, valid_d;

    logic          slot_free;
    logic          chosen_ok;
    logic [SW-1:0] chosen;
    logic          capture;
    logic [W-1:0]  cap_data;

    assign slot_free = !valid_q || out_ready;

`ifdef MUX_RR_EN
    logic [SW-1:0] ptr_q, ptr_d;
    int            idx_i;

    // Walk the search order backwards so the nearest valid channel after ptr wins.
    always_comb begin
        chosen    = sel;
        chosen_ok = (int'(sel) < N);
        idx_i     = 0;
        if (rr_mode) begin
            chosen    = '0;
            chosen_ok = 1'b0;
            for (int k = N; k >= 1; k--) begin
                idx_i = (int'(ptr_q) + k) % N;
                if (in_valid[idx_i[SW-1:0]]) begin
                    chosen    = idx_i[SW-1:0];
                    chosen_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (capture && rr_mode)
            ptr_d = chosen;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= SW'(N - 1);
        else
            ptr_q <= ptr_d;
    end
`else
    always_comb begin
        chosen    = sel;
        chosen_ok = (int'(sel) < N);
    end
`endif

    // Out-of-range selects never match any lane, so nothing is offered or captured.
    always_comb begin
        in_ready = '0;
        cap_data = '0;
        for (int i = 0; i < N; i++) begin
            if (chosen == SW'(i)) begin
                in_ready[i] = chosen_ok && slot_free && !rst;
                cap_data    = in_data[i*W +: W];
            end
        end
    end

    assign capture = |(in_ready & in_valid);

    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        if (capture) begin
            data_d  = cap_data;
            ch_d    = chosen;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
endmodule
